// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - Scan controller bundle: sweep control, mux select/data and sample output.
interface mux_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  logic               Start;
  logic               Stop;
  logic [7:0]         ChanMask;
  logic [DWELL_W-1:0] Dwell;
  logic [2:0]         Sel;
  logic               Enable;
  logic [7:0]         Y;
  logic               OutValid;
  logic               OutReady;
  logic [7:0]         OutData;
  logic [2:0]         OutChan;
  logic               Busy;

  modport master (
    output Start, Stop, ChanMask, Dwell, Y, OutReady,
    input  Sel, Enable, OutValid, OutData, OutChan, Busy
  );

  modport slave (
    input  Start, Stop, ChanMask, Dwell, Y, OutReady,
    output Sel, Enable, OutValid, OutData, OutChan, Busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - Round-robin channel scanner driving an 8-input registered byte mux.
// Define MUX_SCAN_CONTINUOUS_EN to wrap at end of sweep instead of returning to IDLE.
module mux_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, CAPTURE} state_e;

  state_e             state_q;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [2:0]         chan_q;
  logic               stop_q;
  logic [2:0]         sel_q;
  logic               enable_q;
  logic               out_valid_q;
  logic [7:0]         out_data_q;
  logic [2:0]         out_chan_q;

  logic [2:0]         next_chan_d;
  logic               has_next_d;
  logic               out_free_d;
  logic               capture_fire_d;
  logic               stop_now_d;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = i[2:0];
    end
  endfunction

  // Next higher enabled channel; has_next_d low marks the end of the sweep.
  always_comb begin
    next_chan_d = chan_q;
    has_next_d  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (i[2:0] > chan_q)) begin
        next_chan_d = i[2:0];
        has_next_d  = 1'b1;
      end
    end
  end

  assign out_free_d     = !out_valid_q || bus.OutReady;
  assign capture_fire_d = (state_q == CAPTURE) && out_free_d;
  assign stop_now_d     = stop_q || bus.Stop;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      chan_q   <= '0;
      stop_q   <= 1'b0;
      sel_q    <= '0;
      enable_q <= 1'b0;
    end else begin
      if (bus.Stop && (state_q != IDLE)) stop_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.Start && !bus.Stop && (bus.ChanMask != 8'd0)) begin
            mask_q  <= bus.ChanMask;
            dwell_q <= bus.Dwell;
            cnt_q   <= bus.Dwell;
            chan_q  <= lowest_bit(bus.ChanMask);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            sel_q    <= chan_q;
            enable_q <= 1'b1;
            state_q  <= ISSUE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ISSUE: begin
          enable_q <= 1'b0;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          // Stalls here under back-pressure; Y stays put because Enable is low.
          if (capture_fire_d) begin
            if (stop_now_d) begin
              stop_q  <= 1'b0;
              state_q <= IDLE;
            end else if (has_next_d) begin
              chan_q  <= next_chan_d;
              cnt_q   <= dwell_q;
              state_q <= WAIT;
            end else begin
`ifdef MUX_SCAN_CONTINUOUS_EN
              chan_q  <= lowest_bit(mask_q);
              cnt_q   <= dwell_q;
              state_q <= WAIT;
`else
              state_q <= IDLE;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output holding register: reload and accept may coincide.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else if (capture_fire_d) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.Y;
      out_chan_q  <= chan_q;
    end else if (bus.OutReady) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.Sel      = sel_q;
  assign bus.Enable   = enable_q;
  assign bus.OutValid = out_valid_q;
  assign bus.OutData  = out_data_q;
  assign bus.OutChan  = out_chan_q;
  assign bus.Busy     = (state_q != IDLE);

endmodule
